// File: rtl/network_interface_if.sv
// Signal bundle between a network interface, its host and its router port.
// The master modport is the network interface's view; slave is the host/router side.
interface network_interface_if;
    logic        host_tx_valid;
    logic        host_tx_ready;
    logic [7:0]  host_tx_dest;
    logic [7:0]  host_tx_payload;
    logic [15:0] tx_data;
    logic        tx_enable;
    logic        tx_credit_i;
    logic [15:0] rx_data;
    logic        rx_enable;
    logic        rx_credit_o;
    logic        host_rx_valid;
    logic        host_rx_ready;
    logic [15:0] host_rx_data;
    logic [15:0] tx_count;
    logic [15:0] rx_count;
    logic        err_overflow;
    logic        err_credit;
    logic        err_misroute;

    modport master (
        input  host_tx_valid, host_tx_dest, host_tx_payload, tx_credit_i,
               rx_data, rx_enable, host_rx_ready,
        output host_tx_ready, tx_data, tx_enable, rx_credit_o,
               host_rx_valid, host_rx_data, tx_count, rx_count,
               err_overflow, err_credit, err_misroute
    );

    modport slave (
        output host_tx_valid, host_tx_dest, host_tx_payload, tx_credit_i,
               rx_data, rx_enable, host_rx_ready,
        input  host_tx_ready, tx_data, tx_enable, rx_credit_o,
               host_rx_valid, host_rx_data, tx_count, rx_count,
               err_overflow, err_credit, err_misroute
    );
endinterface

// File: rtl/network_interface.sv
// Mesh NoC network interface: credit-based flit injection toward the router
// and a first-word fall-through receive FIFO toward the host.
module network_interface #(
    parameter int unsigned XCOORD   = 0,
    parameter int unsigned YCOORD   = 0,
    parameter int unsigned CREDITS  = 4,
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    network_interface_if.master bus
);

    localparam int PW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int CW = $clog2(RX_DEPTH + 1);
    localparam logic [2:0]    CREDIT_MAX = 3'(CREDITS);
    localparam logic [CW-1:0] FIFO_FULL  = CW'(RX_DEPTH);
    localparam logic [7:0]    LOCAL_ADDR = {4'(XCOORD), 4'(YCOORD)};

    logic [2:0]    credit_q, credit_d;
    logic [15:0]   tx_data_q, tx_data_d;
    logic          tx_enable_q, tx_enable_d;
    logic [15:0]   tx_count_q, tx_count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [15:0]   rx_count_q, rx_count_d;
    logic          rx_credit_q, rx_credit_d;
    logic          err_overflow_q, err_overflow_d;
    logic          err_credit_q, err_credit_d;
    logic          err_misroute_q, err_misroute_d;
    logic [15:0]   mem_q [RX_DEPTH];

    logic tx_accept;
    logic rx_pop;
    logic rx_full;
    logic rx_push;

    assign tx_accept = bus.host_tx_valid & (credit_q != 3'd0);
    assign rx_pop    = (fifo_cnt_q != '0) & bus.host_rx_ready;
    assign rx_full   = (fifo_cnt_q == FIFO_FULL);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign rx_push   = bus.rx_enable & (~rx_full | rx_pop);

    always_comb begin
        credit_d       = credit_q;
        tx_data_d      = tx_data_q;
        tx_enable_d    = tx_accept;
        tx_count_d     = tx_count_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        fifo_cnt_d     = fifo_cnt_q;
        rx_count_d     = rx_count_q;
        rx_credit_d    = rx_pop;
        err_overflow_d = err_overflow_q;
        err_credit_d   = err_credit_q;
        err_misroute_d = err_misroute_q;

        if (tx_accept) begin
            tx_data_d  = {bus.host_tx_payload, bus.host_tx_dest};
            tx_count_d = tx_count_q + 16'd1;
        end

        // Surplus credits are dropped so the count never exceeds the router FIFO depth.
        case ({tx_accept, bus.tx_credit_i})
            2'b10: credit_d = credit_q - 3'd1;
            2'b01: begin
                if (credit_q == CREDIT_MAX) err_credit_d = 1'b1;
                else                        credit_d     = credit_q + 3'd1;
            end
            default: ;
        endcase

        if (rx_push) begin
            wr_ptr_d   = wr_ptr_q + PW'(1);
            rx_count_d = rx_count_q + 16'd1;
            if (bus.rx_data[7:0] != LOCAL_ADDR) err_misroute_d = 1'b1;
        end
        if (bus.rx_enable && !rx_push) err_overflow_d = 1'b1;
        if (rx_pop) rd_ptr_d = rd_ptr_q + PW'(1);

        case ({rx_push, rx_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q       <= CREDIT_MAX;
            tx_data_q      <= '0;
            tx_enable_q    <= 1'b0;
            tx_count_q     <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fifo_cnt_q     <= '0;
            rx_count_q     <= '0;
            rx_credit_q    <= 1'b0;
            err_overflow_q <= 1'b0;
            err_credit_q   <= 1'b0;
            err_misroute_q <= 1'b0;
        end else begin
            credit_q       <= credit_d;
            tx_data_q      <= tx_data_d;
            tx_enable_q    <= tx_enable_d;
            tx_count_q     <= tx_count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fifo_cnt_q     <= fifo_cnt_d;
            rx_count_q     <= rx_count_d;
            rx_credit_q    <= rx_credit_d;
            err_overflow_q <= err_overflow_d;
            err_credit_q   <= err_credit_d;
            err_misroute_q <= err_misroute_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) mem_q[wr_ptr_q] <= bus.rx_data;
    end

    assign bus.host_tx_ready = (credit_q != 3'd0);
    assign bus.tx_data       = tx_data_q;
    assign bus.tx_enable     = tx_enable_q;
    assign bus.tx_count      = tx_count_q;
    assign bus.rx_credit_o   = rx_credit_q;
    assign bus.host_rx_valid = (fifo_cnt_q != '0);
    assign bus.host_rx_data  = mem_q[rd_ptr_q];
    assign bus.rx_count      = rx_count_q;
    assign bus.err_overflow  = err_overflow_q;
    assign bus.err_credit    = err_credit_q;
    assign bus.err_misroute  = err_misroute_q;

endmodule

// File: tb/tb_network_interface.sv
// Scoreboard bench for network_interface at router (2,3), 4 credits, 4-deep RX FIFO.
module tb_network_interface;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    network_interface_if bus();

    network_interface #(
        .XCOORD(2), .YCOORD(3), .CREDITS(4), .RX_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [15:0] txExp[$];
    logic [15:0] rxExp[$];
    int mCredit;
    int mTxCount;
    int mRxCount;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.host_tx_valid   = 1'b0;
        bus.host_tx_dest    = 8'h00;
        bus.host_tx_payload = 8'h00;
        bus.tx_credit_i     = 1'b0;
        bus.rx_data         = 16'h0000;
        bus.rx_enable       = 1'b0;
        bus.host_rx_ready   = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        txExp.delete();
        rxExp.delete();
        mCredit  = 4;
        mTxCount = 0;
        mRxCount = 0;
    endtask

    task automatic test_reset();
        idleInputs();
        doReset();
        vectors++;
        if (bus.host_tx_ready !== 1'b1) begin
            miscompares++; $display("[TB] FAIL reset_tx_ready: got %b expected 1", bus.host_tx_ready);
        end
        vectors++;
        if (bus.tx_enable !== 1'b0 || bus.tx_data !== 16'h0000) begin
            miscompares++; $display("[TB] FAIL reset_tx: got en=%b data=%h expected en=0 data=0000", bus.tx_enable, bus.tx_data);
        end
        vectors++;
        if (bus.host_rx_valid !== 1'b0 || bus.rx_credit_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_rx: got valid=%b credit=%b expected 0 0", bus.host_rx_valid, bus.rx_credit_o);
        end
        vectors++;
        if (bus.tx_count !== 16'h0 || bus.rx_count !== 16'h0) begin
            miscompares++; $display("[TB] FAIL reset_counts: got tx=%h rx=%h expected 0 0", bus.tx_count, bus.rx_count);
        end
        vectors++;
        if ({bus.err_overflow, bus.err_credit, bus.err_misroute} !== 3'b000) begin
            miscompares++; $display("[TB] FAIL reset_errs: got %b expected 000", {bus.err_overflow, bus.err_credit, bus.err_misroute});
        end
    endtask

    task automatic test_credit_exhaust();
        int pulses = 0;
        logic expReady;
        logic [15:0] expData;
        logic [15:0] lastSent = 16'h0000;
        bus.host_tx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.host_tx_dest    = 8'(8'h10 + i);
            bus.host_tx_payload = 8'(8'hA0 + i);
            #1;
            expReady = (mCredit != 0);
            vectors++;
            if (bus.host_tx_ready !== expReady) begin
                miscompares++; $display("[TB] FAIL exhaust_ready[%0d]: got %b expected %b", i, bus.host_tx_ready, expReady);
            end
            if (expReady) begin
                lastSent = {bus.host_tx_payload, bus.host_tx_dest};
                txExp.push_back(lastSent);
                mCredit--;
                mTxCount++;
            end
            step();
            if (bus.tx_enable === 1'b1) begin
                pulses++;
                vectors++;
                expData = (txExp.size() != 0) ? txExp.pop_front() : 16'hxxxx;
                if (bus.tx_data !== expData) begin
                    miscompares++; $display("[TB] FAIL exhaust_data[%0d]: got %h expected %h", i, bus.tx_data, expData);
                end
            end
        end
        bus.host_tx_valid = 1'b0;
        step();
        vectors++;
        if (pulses !== 4 || txExp.size() != 0) begin
            miscompares++; $display("[TB] FAIL exhaust_pulses: got %0d pending %0d expected 4 pending 0", pulses, txExp.size());
        end
        vectors++;
        if (bus.host_tx_ready !== 1'b0 || bus.tx_count !== 16'(mTxCount)) begin
            miscompares++; $display("[TB] FAIL exhaust_state: got ready=%b count=%0d expected ready=0 count=%0d", bus.host_tx_ready, bus.tx_count, mTxCount);
        end
        vectors++;
        if (bus.tx_enable !== 1'b0 || bus.tx_data !== lastSent) begin
            miscompares++; $display("[TB] FAIL idle_hold: got en=%b data=%h expected en=0 data=%h", bus.tx_enable, bus.tx_data, lastSent);
        end
    endtask

    task automatic test_credit_return();
        int accepts = 0;
        logic [15:0] expData;
        bus.tx_credit_i = 1'b1;
        step();
        bus.tx_credit_i = 1'b0;
        mCredit++;
        vectors++;
        if (bus.host_tx_ready !== 1'b1) begin
            miscompares++; $display("[TB] FAIL credit_return_ready: got %b expected 1", bus.host_tx_ready);
        end
        // Send and credit in the same cycle leave exactly one credit behind.
        for (int i = 0; i < 2; i++) begin
            bus.host_tx_valid   = 1'b1;
            bus.tx_credit_i     = (i == 0);
            bus.host_tx_dest    = 8'h23;
            bus.host_tx_payload = 8'(8'h5A + i);
            txExp.push_back({bus.host_tx_payload, bus.host_tx_dest});
            mTxCount++;
            step();
            bus.host_tx_valid = 1'b0;
            bus.tx_credit_i   = 1'b0;
            expData = txExp.pop_front();
            vectors++;
            if (bus.tx_enable !== 1'b1 || bus.tx_data !== expData) begin
                miscompares++; $display("[TB] FAIL concurrent_tx[%0d]: got en=%b data=%h expected en=1 data=%h", i, bus.tx_enable, bus.tx_data, expData);
            end
            vectors++;
            if (bus.host_tx_ready !== (i == 0)) begin
                miscompares++; $display("[TB] FAIL concurrent_ready[%0d]: got %b expected %b", i, bus.host_tx_ready, (i == 0));
            end
        end
        mCredit = 0;
        for (int i = 0; i < 4; i++) begin
            bus.tx_credit_i = 1'b1;
            step();
            mCredit++;
        end
        vectors++;
        if (bus.err_credit !== 1'b0) begin
            miscompares++; $display("[TB] FAIL credit_full_no_err: got %b expected 0", bus.err_credit);
        end
        step();
        bus.tx_credit_i = 1'b0;
        vectors++;
        if (bus.err_credit !== 1'b1) begin
            miscompares++; $display("[TB] FAIL err_credit: got %b expected 1", bus.err_credit);
        end
        // The surplus credit must not have raised the count above four.
        bus.host_tx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bus.host_tx_ready === 1'b1) accepts++;
            step();
        end
        bus.host_tx_valid = 1'b0;
        mTxCount += 4;
        vectors++;
        if (accepts !== 4 || bus.tx_count !== 16'(mTxCount)) begin
            miscompares++; $display("[TB] FAIL credit_saturate: got accepts=%0d count=%0d expected 4 %0d", accepts, bus.tx_count, mTxCount);
        end
    endtask

    task automatic test_rx_basic();
        logic [15:0] expData;
        bus.rx_enable = 1'b1;
        bus.rx_data   = 16'hAB23;
        rxExp.push_back(16'hAB23);
        mRxCount++;
        step();
        bus.rx_enable = 1'b0;
        step();
        expData = rxExp[0];
        vectors++;
        if (bus.host_rx_valid !== 1'b1 || bus.host_rx_data !== expData) begin
            miscompares++; $display("[TB] FAIL rx_head: got valid=%b data=%h expected valid=1 data=%h", bus.host_rx_valid, bus.host_rx_data, expData);
        end
        vectors++;
        if (bus.err_misroute !== 1'b0 || bus.rx_count !== 16'(mRxCount)) begin
            miscompares++; $display("[TB] FAIL rx_local: got misroute=%b count=%0d expected 0 %0d", bus.err_misroute, bus.rx_count, mRxCount);
        end
        bus.host_rx_ready = 1'b1;
        step();
        bus.host_rx_ready = 1'b0;
        void'(rxExp.pop_front());
        vectors++;
        if (bus.rx_credit_o !== 1'b1 || bus.host_rx_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL rx_pop_credit: got credit=%b valid=%b expected 1 0", bus.rx_credit_o, bus.host_rx_valid);
        end
        step();
        vectors++;
        if (bus.rx_credit_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL rx_credit_width: got %b expected 0", bus.rx_credit_o);
        end
    endtask

    task automatic test_overflow();
        int mFifo = 0;
        logic expOvf = 1'b0;
        logic [15:0] expData;
        doReset();
        for (int i = 0; i < 5; i++) begin
            bus.rx_enable = 1'b1;
            bus.rx_data   = {8'(8'hC0 + i), 8'h23};
            if (mFifo < 4) begin
                rxExp.push_back(bus.rx_data);
                mFifo++;
                mRxCount++;
            end else begin
                expOvf = 1'b1;
            end
            step();
            vectors++;
            if (bus.err_overflow !== expOvf) begin
                miscompares++; $display("[TB] FAIL overflow_flag[%0d]: got %b expected %b", i, bus.err_overflow, expOvf);
            end
        end
        vectors++;
        if (bus.rx_count !== 16'(mRxCount)) begin
            miscompares++; $display("[TB] FAIL overflow_count: got %0d expected %0d", bus.rx_count, mRxCount);
        end
        bus.rx_data       = 16'hD023;
        bus.host_rx_ready = 1'b1;
        expData = rxExp.pop_front();
        rxExp.push_back(16'hD023);
        mRxCount++;
        vectors++;
        if (bus.host_rx_data !== expData) begin
            miscompares++; $display("[TB] FAIL full_pushpop_head: got %h expected %h", bus.host_rx_data, expData);
        end
        step();
        bus.rx_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expData = rxExp.pop_front();
            vectors++;
            if (bus.host_rx_valid !== 1'b1 || bus.host_rx_data !== expData) begin
                miscompares++; $display("[TB] FAIL drain[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, bus.host_rx_valid, bus.host_rx_data, expData);
            end
            step();
        end
        bus.host_rx_ready = 1'b0;
        vectors++;
        if (bus.host_rx_valid !== 1'b0 || bus.rx_count !== 16'(mRxCount) || bus.err_overflow !== 1'b1) begin
            miscompares++; $display("[TB] FAIL drain_end: got valid=%b count=%0d ovf=%b expected 0 %0d 1", bus.host_rx_valid, bus.rx_count, bus.err_overflow, mRxCount);
        end
    endtask

    task automatic test_misroute();
        logic [15:0] expData;
        bus.rx_enable = 1'b1;
        bus.rx_data   = 16'h0011;
        rxExp.push_back(16'h0011);
        mRxCount++;
        step();
        bus.rx_enable = 1'b0;
        expData = rxExp[0];
        vectors++;
        if (bus.err_misroute !== 1'b1 || bus.host_rx_valid !== 1'b1 || bus.host_rx_data !== expData) begin
            miscompares++; $display("[TB] FAIL misroute: got err=%b valid=%b data=%h expected 1 1 %h", bus.err_misroute, bus.host_rx_valid, bus.host_rx_data, expData);
        end
        bus.host_rx_ready = 1'b1;
        step();
        bus.host_rx_ready = 1'b0;
        void'(rxExp.pop_front());
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 2; i++) begin
            bus.rx_enable = 1'b1;
            bus.rx_data   = {8'(8'hE0 + i), 8'h23};
            step();
        end
        bus.rx_enable       = 1'b0;
        bus.host_tx_valid   = 1'b1;
        bus.host_tx_dest    = 8'h45;
        bus.host_tx_payload = 8'h99;
        step();
        bus.host_tx_valid = 1'b0;
        vectors++;
        if (bus.tx_enable !== 1'b1 || bus.tx_data !== 16'h9945 || bus.host_rx_valid !== 1'b1) begin
            miscompares++; $display("[TB] FAIL midop_setup: got en=%b data=%h rxv=%b expected 1 9945 1", bus.tx_enable, bus.tx_data, bus.host_rx_valid);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (bus.tx_enable !== 1'b0 || bus.tx_data !== 16'h0 || bus.host_rx_valid !== 1'b0 || bus.rx_credit_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL midop_async_data: got en=%b data=%h rxv=%b cr=%b expected 0 0000 0 0", bus.tx_enable, bus.tx_data, bus.host_rx_valid, bus.rx_credit_o);
        end
        vectors++;
        if (bus.tx_count !== 16'h0 || bus.rx_count !== 16'h0 || {bus.err_overflow, bus.err_credit, bus.err_misroute} !== 3'b000 || bus.host_tx_ready !== 1'b1) begin
            miscompares++; $display("[TB] FAIL midop_async_state: got tx=%h rx=%h errs=%b ready=%b expected 0 0 000 1", bus.tx_count, bus.rx_count, {bus.err_overflow, bus.err_credit, bus.err_misroute}, bus.host_tx_ready);
        end
        #1 rst = 1'b0;
        txExp.delete();
        rxExp.delete();
        step();
        vectors++;
        if (bus.tx_enable !== 1'b0 || bus.host_rx_valid !== 1'b0 || bus.host_tx_ready !== 1'b1) begin
            miscompares++; $display("[TB] FAIL midop_after: got en=%b rxv=%b ready=%b expected 0 0 1", bus.tx_enable, bus.host_rx_valid, bus.host_tx_ready);
        end
    endtask

    initial begin
        rst = 1'b1;
        idleInputs();
        test_reset();
        test_credit_exhaust();
        test_credit_return();
        test_rx_basic();
        test_overflow();
        test_misroute();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/network_interface.md
NETWORK_INTERFACE -- requirements
Module: network_interface

Interface
REQ-001 SHALL have parameter XCOORD, default 0, 4-bit X coordinate of the attached router.
REQ-002 SHALL have parameter YCOORD, default 0, 4-bit Y coordinate of the attached router.
REQ-003 SHALL have parameter CREDITS, default 4, 1..7, depth of the router local input FIFO.
REQ-004 SHALL have parameter RX_DEPTH, default 4, power of two, local receive FIFO depth.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  clock; rst  in  1  async active-high reset.
REQ-006 SHALL have port host_tx_valid  in  1  host flit request.
REQ-007 SHALL have port host_tx_ready  out  1  request accepted this cycle.
REQ-008 SHALL have port host_tx_dest  in  8  {dest X[7:4], dest Y[3:0]}.
REQ-009 SHALL have port host_tx_payload  in  8  flit payload.
REQ-010 SHALL have port tx_data  out  16  flit to the router local input.
REQ-011 SHALL have port tx_enable  out  1  flit-valid strobe.
REQ-012 SHALL have port tx_credit_i  in  1  one-cycle credit return from the router.
REQ-013 SHALL have port rx_data  in  16  flit from the router local output.
REQ-014 SHALL have port rx_enable  in  1  flit-valid strobe.
REQ-015 SHALL have port rx_credit_o  out  1  one-cycle credit return to the router.
REQ-016 SHALL have ports host_rx_valid  out  1, host_rx_ready  in  1, host_rx_data  out  16: receive handshake.
REQ-017 SHALL have ports tx_count  out  16 and rx_count  out  16: flit counters.
REQ-018 SHALL have ports err_overflow  out  1, err_credit  out  1, err_misroute  out  1: sticky error flags.

Function
REQ-019 Flit format SHALL be [15:8] payload, [7:4] dest X, [3:0] dest Y.
REQ-020 credit_cnt SHALL be 3 bits wide; host_tx_ready SHALL equal (credit_cnt != 0), combinational.
REQ-021 On host_tx_valid & host_tx_ready at a clk edge: tx_data <= {payload, dest}, tx_enable <= 1 for exactly one cycle, tx_count += 1, credit_cnt -= 1.
REQ-022 With no accepted request, tx_enable SHALL be 0; tx_data SHALL hold its last value.
REQ-023 Back-to-back accepts SHALL give consecutive tx_enable pulses while credits remain; latency from accept to tx_enable is 1 cycle.
REQ-024 tx_credit_i SHALL increment credit_cnt; a concurrent send and credit SHALL leave credit_cnt unchanged.
REQ-025 A credit arriving at credit_cnt == CREDITS with no concurrent send SHALL be ignored (saturate) and SHALL set err_credit.
REQ-026 rx_enable SHALL push rx_data into the RX FIFO and increment rx_count.
REQ-027 A push while full without a concurrent pop SHALL drop the flit, leave rx_count unchanged, and set err_overflow.
REQ-028 A push while full with a concurrent pop SHALL be accepted.
REQ-029 A pushed flit with [7:0] != {XCOORD, YCOORD} SHALL still be stored and SHALL set err_misroute.
REQ-030 host_rx_valid SHALL equal FIFO not empty; host_rx_data SHALL be the FIFO head (first-word fall-through).
REQ-031 A pop SHALL occur on host_rx_valid & host_rx_ready; rx_credit_o SHALL pulse high for one cycle on the cycle after each pop.
REQ-032 FIFO pointers SHALL wrap modulo RX_DEPTH; the FIFO SHALL use a count of RX_DEPTH+1 states to distinguish full from empty.
REQ-033 tx_count and rx_count SHALL wrap from 0xFFFF to 0x0000.
REQ-034 Error flags SHALL clear only on rst.

Reset
REQ-035 rst SHALL asynchronously force credit_cnt=CREDITS, tx_enable=0, tx_data=0, rx_credit_o=0, FIFO empty (host_rx_valid=0), counters=0, and all error flags=0.
REQ-036 A reset asserted mid-operation SHALL discard any in-flight flit and pending credit pulse; the first edge after deassertion SHALL behave as post-reset.

Verification
REQ-037 CREDITS=4, host_tx_valid held high, no credits returned -> exactly 4 tx_enable pulses, then host_tx_ready=0, tx_count=4.
REQ-038 Credit count 0, then tx_credit_i pulse -> host_tx_ready=1 the next cycle; send and credit in the same cycle -> count unchanged.
REQ-039 XCOORD=2, YCOORD=3, push 0xAB23 with host_rx_ready=0 -> host_rx_valid=1, host_rx_data=0xAB23, err_misroute=0; pop -> rx_credit_o pulses one cycle later.
REQ-040 RX_DEPTH=4, five pushes with no pops -> fifth flit dropped, err_overflow=1, rx_count=4; full FIFO with push and pop in the same cycle -> no drop.
REQ-041 Push 0x0011 at XCOORD=2, YCOORD=3 -> err_misroute=1 and the flit is stored; extra credit at credit_cnt=CREDITS -> err_credit=1.
REQ-042 Assert rst asynchronously while tx_enable=1 and the FIFO holds 2 flits -> all outputs at reset values immediately; host_tx_ready=1 after deassertion.
